// File: rtl/parking_pkg.sv
// Shared widths and FSM state encoding for the parking exit-side billing logic.
package parking_pkg;

  localparam int CAR_SLOTS = 3;
  localparam int ID_W      = 2;
  localparam int TIME_W    = 8;
  localparam int FEE_W     = 12;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CALC,
    WAIT_PAY,
    OPEN,
    ERR
  } state_t;

endpackage

// File: rtl/parking_fee_calc.sv
// Combinational fee: wrap-around elapsed time, minimum one unit, times RATE.
module parking_fee_calc
  import parking_pkg::*;
#(
  parameter int RATE = 2
) (
  input  logic [TIME_W-1:0] entry_time,
  input  logic [TIME_W-1:0] now_time,
  output logic [FEE_W-1:0]  fee
);

  logic [TIME_W-1:0] dur;
  logic [TIME_W-1:0] units;

  always_comb begin
    dur   = now_time - entry_time;
    // A car leaving in the same time unit it entered still pays one unit.
    units = (dur == '0) ? TIME_W'(1) : dur;
    fee   = FEE_W'(units) * FEE_W'(RATE);
  end

endmodule

// File: rtl/parking_exit_fee.sv
// Exit billing controller: validate slot, read entry time, present fee,
// wait for payment, release the slot and hold the gate open.
module parking_exit_fee
  import parking_pkg::*;
#(
  parameter int RATE             = 2,
  parameter int GATE_OPEN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 exit_req,
  input  logic [ID_W-1:0]      exit_car_id,
  input  logic [CAR_SLOTS-1:0] slot_occupied,
  input  logic [TIME_W-1:0]    current_time,
  input  logic [TIME_W-1:0]    entry_time,
  input  logic                 pay_done,
  input  logic                 exit_cancel,
  output logic                 buf_read_enable,
  output logic [ID_W-1:0]      buf_car_id,
  output logic [FEE_W-1:0]     fee,
  output logic                 fee_valid,
  output logic                 slot_release,
  output logic [ID_W-1:0]      release_id,
  output logic                 gate_open,
  output logic                 busy,
  output logic                 error
);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [TIME_W-1:0]   entry_q, entry_d;
  logic [TIME_W-1:0]   now_q, now_d;
  logic [FEE_W-1:0]    fee_q, fee_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [FEE_W-1:0]    fee_calc;
  logic [CAR_SLOTS:0]  occ_ext;
  logic                req_ok;

  parking_fee_calc #(
    .RATE (RATE)
  ) u_fee_calc (
    .entry_time (entry_q),
    .now_time   (now_q),
    .fee        (fee_calc)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    entry_d = entry_q;
    now_d   = now_q;
    fee_d   = fee_q;
    cnt_d   = cnt_q;
    // Id 3 indexes the padding zero, so out-of-range ids fail the same check.
    occ_ext = {1'b0, slot_occupied};
    req_ok  = occ_ext[exit_car_id];

    case (state_q)
      IDLE: begin
        if (exit_req) begin
          id_d    = exit_car_id;
          state_d = req_ok ? READ : ERR;
        end
      end
      READ: begin
        entry_d = entry_time;
        now_d   = current_time;
        state_d = CALC;
      end
      CALC: begin
        fee_d   = fee_calc;
        state_d = WAIT_PAY;
      end
      WAIT_PAY: begin
        if (pay_done) begin
          cnt_d   = 4'(GATE_OPEN_CYCLES);
          state_d = OPEN;
        end else if (exit_cancel) begin
          state_d = IDLE;
        end
      end
      OPEN: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      entry_q <= '0;
      now_q   <= '0;
      fee_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      entry_q <= entry_d;
      now_q   <= now_d;
      fee_q   <= fee_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode purely from registers so an async reset clears them at once.
  assign buf_read_enable = (state_q == READ);
  assign buf_car_id      = buf_read_enable ? id_q : '0;
  assign fee             = fee_q;
  assign fee_valid       = (state_q == WAIT_PAY);
  assign gate_open       = (state_q == OPEN);
  assign slot_release    = gate_open && (cnt_q == 4'(GATE_OPEN_CYCLES));
  assign release_id      = slot_release ? id_q : '0;
  assign busy            = (state_q != IDLE);
  assign error           = (state_q == ERR);

endmodule

// File: tb/tb_parking_exit_fee.sv
// Bench for parking_exit_fee: expected fees and release ids are queued at
// stimulus time and compared when the DUT presents them.
module tb_parking_exit_fee;
  import parking_pkg::*;

  localparam int RATE = 2;
  localparam int GOC  = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 exit_req;
  logic [ID_W-1:0]      exit_car_id;
  logic [CAR_SLOTS-1:0] slot_occupied;
  logic [TIME_W-1:0]    current_time;
  logic [TIME_W-1:0]    entry_time;
  logic                 pay_done;
  logic                 exit_cancel;
  logic                 buf_read_enable;
  logic [ID_W-1:0]      buf_car_id;
  logic [FEE_W-1:0]     fee;
  logic                 fee_valid;
  logic                 slot_release;
  logic [ID_W-1:0]      release_id;
  logic                 gate_open;
  logic                 busy;
  logic                 error;

  logic [TIME_W-1:0] mem [0:3];
  logic [FEE_W-1:0]  exp_fee [$];
  logic [ID_W-1:0]   exp_rel [$];
  int total = 0;
  int bad   = 0;
  int rd_cnt  = 0;
  int rel_cnt = 0;
  int err_cnt = 0;
  logic fv_prev = 1'b0;

  parking_exit_fee #(
    .RATE             (RATE),
    .GATE_OPEN_CYCLES (GOC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .exit_req        (exit_req),
    .exit_car_id     (exit_car_id),
    .slot_occupied   (slot_occupied),
    .current_time    (current_time),
    .entry_time      (entry_time),
    .pay_done        (pay_done),
    .exit_cancel     (exit_cancel),
    .buf_read_enable (buf_read_enable),
    .buf_car_id      (buf_car_id),
    .fee             (fee),
    .fee_valid       (fee_valid),
    .slot_release    (slot_release),
    .release_id      (release_id),
    .gate_open       (gate_open),
    .busy            (busy),
    .error           (error)
  );

  always #5 clk = ~clk;

  // Entry-time buffer model with combinational read.
  assign entry_time = buf_read_enable ? mem[buf_car_id] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: pop expectations when the DUT presents a fee or a release.
  always @(negedge clk) begin
    if (!reset) begin
      if (buf_read_enable) rd_cnt++;
      if (error) err_cnt++;
      if (fee_valid && !fv_prev) begin
        if (exp_fee.size() == 0) chk("fee_unexpected", 32'(fee), 32'hffff_ffff);
        else chk("fee", 32'(fee), 32'(exp_fee.pop_front()));
      end
      if (slot_release) begin
        rel_cnt++;
        if (exp_rel.size() == 0) chk("release_unexpected", 32'(release_id), 32'hffff_ffff);
        else chk("release_id", 32'(release_id), 32'(exp_rel.pop_front()));
      end
    end
    fv_prev = fee_valid;
  end

  task automatic start_exit(input logic [1:0] id, input logic [7:0] ent,
                            input logic [7:0] now, input logic [11:0] efee);
    mem[id]      = ent;
    current_time = now;
    exit_car_id  = id;
    exit_req     = 1'b1;
    exp_fee.push_back(efee);
    @(negedge clk);
    exit_req = 1'b0;
    chk("read_en", 32'(buf_read_enable), 1);
    chk("buf_car_id", 32'(buf_car_id), 32'(id));
    chk("busy_read", 32'(busy), 1);
    @(negedge clk);
    current_time = now + 8'd77;
    chk("read_en_one_cycle", 32'(buf_read_enable), 0);
    chk("buf_car_id_idle", 32'(buf_car_id), 0);
    chk("fee_valid_early", 32'(fee_valid), 0);
    @(negedge clk);
    chk("fee_valid_cycle3", 32'(fee_valid), 1);
    $display("exit id=%0d entry=%0d now=%0d fee=%0d", id, ent, now, fee);
  endtask

  task automatic pay(input logic cancel_too, input logic [1:0] id);
    int n;
    int r0;
    r0          = rel_cnt;
    pay_done    = 1'b1;
    exit_cancel = cancel_too;
    exp_rel.push_back(id);
    @(negedge clk);
    pay_done    = 1'b0;
    exit_cancel = 1'b0;
    chk("gate_first", 32'(gate_open), 1);
    chk("release_pulse", 32'(slot_release), 1);
    chk("fee_valid_off", 32'(fee_valid), 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!gate_open) break;
      n++;
      @(negedge clk);
    end
    #1;
    chk("gate_cycles", 32'(n), GOC);
    chk("busy_after_open", 32'(busy), 0);
    chk("release_count", 32'(rel_cnt - r0), 1);
    $display("pay id=%0d cancel_too=%0d gate_cycles=%0d", id, cancel_too, n);
  endtask

  task automatic cancel();
    int r0;
    r0          = rel_cnt;
    exit_cancel = 1'b1;
    @(negedge clk);
    exit_cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 0);
    chk("cancel_fee_valid", 32'(fee_valid), 0);
    chk("cancel_gate", 32'(gate_open), 0);
    repeat (2) @(negedge clk);
    #1;
    chk("cancel_no_gate", 32'(gate_open), 0);
    chk("cancel_no_release", 32'(rel_cnt - r0), 0);
    $display("cancel done");
  endtask

  task automatic reject(input logic [1:0] id);
    int r0;
    int e0;
    r0          = rd_cnt;
    e0          = err_cnt;
    exit_car_id = id;
    exit_req    = 1'b1;
    @(negedge clk);
    exit_req = 1'b0;
    chk("reject_error", 32'(error), 1);
    chk("reject_read_en", 32'(buf_read_enable), 0);
    @(negedge clk);
    chk("reject_error_one", 32'(error), 0);
    chk("reject_idle", 32'(busy), 0);
    #1;
    chk("reject_no_read", 32'(rd_cnt - r0), 0);
    chk("reject_err_count", 32'(err_cnt - e0), 1);
    $display("reject id=%0d", id);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    reset         = 1'b1;
    exit_req      = 1'b0;
    exit_car_id   = '0;
    slot_occupied = 3'b110;
    current_time  = '0;
    pay_done      = 1'b0;
    exit_cancel   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fee", 32'(fee), 0);
    chk("rst_outputs", 32'({buf_read_enable, fee_valid, slot_release, gate_open, error}), 0);
    reset = 1'b0;
    @(negedge clk);

    // Normal exit; later time changes must not alter the presented fee.
    start_exit(2'd1, 8'd10, 8'd25, 12'd30);
    @(negedge clk);
    chk("fee_stable", 32'(fee), 30);
    pay(1'b0, 2'd1);

    // Wrap-around, with exit_req held during WAIT_PAY, then simultaneous pay/cancel.
    start_exit(2'd2, 8'd250, 8'd5, 12'd22);
    r0          = rd_cnt;
    exit_car_id = 2'd1;
    exit_req    = 1'b1;
    repeat (3) @(negedge clk);
    exit_req = 1'b0;
    #1;
    chk("held_req_fee_valid", 32'(fee_valid), 1);
    chk("held_req_fee", 32'(fee), 22);
    chk("held_req_no_read", 32'(rd_cnt - r0), 0);
    pay(1'b1, 2'd2);

    // Zero duration charges the minimum unit, then cancel.
    start_exit(2'd1, 8'd40, 8'd40, 12'd2);
    cancel();

    // Largest duration, then reset in the second OPEN cycle.
    start_exit(2'd2, 8'd0, 8'd255, 12'd510);
    pay_done = 1'b1;
    exp_rel.push_back(2'd2);
    @(negedge clk);
    pay_done = 1'b0;
    chk("open1_gate", 32'(gate_open), 1);
    @(negedge clk);
    chk("open2_gate", 32'(gate_open), 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_gate", 32'(gate_open), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_release", 32'(slot_release), 0);
    $display("reset during OPEN");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Processing resumes normally after reset.
    start_exit(2'd1, 8'd100, 8'd103, 12'd6);
    pay(1'b0, 2'd1);

    reject(2'd3);
    reject(2'd0);

    chk("fee_queue_empty", 32'(exp_fee.size()), 0);
    chk("rel_queue_empty", 32'(exp_rel.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_exit_fee.md
# parking_exit_fee

Exit-side billing controller of the car parking system, directly downstream of the entry-time storage buffer. On an exit request it validates the slot, reads the car's stored entry time through the buffer's read port, and computes the parking fee from the elapsed 8-bit time. It then waits for payment confirmation, releases the slot and holds the exit gate open for a fixed number of cycles.

## Interface
- RATE, default 2: fee per elapsed time unit, 1..15.
- GATE_OPEN_CYCLES, default 4: cycles gate_open stays high, 1..15.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- exit_req  in  1  exit request; sampled only in IDLE.
- exit_car_id  in  2  slot id of the exiting car; valid 0..2.
- slot_occupied  in  3  per-slot occupancy mask from the entry side.
- current_time  in  8  free-running time counter (wraps 255→0).
- entry_time  in  8  buffer read data (combinational from buf_car_id/buf_read_enable).
- pay_done  in  1  payment confirmed; sampled only in WAIT_PAY.
- exit_cancel  in  1  abort billing; sampled only in WAIT_PAY.
- buf_read_enable  out  1  buffer read enable.
- buf_car_id  out  2  buffer read address.
- fee  out  12  computed fee, stable while fee_valid.
- fee_valid  out  1  fee presented, awaiting payment.
- slot_release  out  1  one-cycle pulse: slot freed.
- release_id  out  2  id accompanying slot_release.
- gate_open  out  1  exit barrier open.
- busy  out  1  high in any state other than IDLE.
- error  out  1  one-cycle pulse: rejected request.

## Operation
- FSM states: IDLE, READ, CALC, WAIT_PAY, OPEN, ERR. All outputs are decoded from registered state and registers.
- IDLE: exit_req=1 latches exit_car_id into id_r.
  - If exit_car_id>2 or slot_occupied[exit_car_id]=0, go to ERR.
  - Otherwise go to READ.
- READ: buf_read_enable=1, buf_car_id=id_r. On the edge, register entry_r<=entry_time and now_r<=current_time, then go to CALC.
- CALC: dur = (now_r − entry_r) mod 256, an 8-bit wrap subtraction.
  - units = (dur==0) ? 1 : dur. The minimum charge is one unit.
  - fee_r <= units*RATE, zero-extended to 12 bits with no overflow, because 255*15=3825.
  - Then go to WAIT_PAY.
- WAIT_PAY: fee_valid=1 and fee=fee_r.
  - pay_done=1 goes to OPEN and loads gate counter = GATE_OPEN_CYCLES.
  - exit_cancel=1 (without pay_done) goes to IDLE, with no release and no gate.
  - If both are high in the same cycle, pay_done wins.
- OPEN: gate_open=1. slot_release=1 and release_id=id_r in the first OPEN cycle only. The counter decrements each cycle; leave for IDLE when it reaches 1.
- ERR: error=1 for one cycle, then go to IDLE. No buffer read occurs.
- exit_req outside IDLE is ignored, not queued.
- buf_car_id drives 0 whenever buf_read_enable=0.

## Timing
- Reset (asynchronous): state IDLE; id_r, entry_r, now_r, fee_r and the counter all 0.
  - All outputs go to 0 immediately, including gate_open when reset arrives mid-OPEN.
- exit_req high in cycle 0 (valid): READ in cycle 1 (buf_read_enable high for exactly 1 cycle), CALC in cycle 2, fee_valid high from cycle 3.
- Invalid exit_req in cycle 0: error high in cycle 1, IDLE in cycle 2.
- pay_done high in cycle n: gate_open high in cycles n+1 .. n+GATE_OPEN_CYCLES; slot_release in cycle n+1; busy low from cycle n+GATE_OPEN_CYCLES+1.
- fee is based on the current_time sampled in READ; later time changes do not alter it.
- fee holds its last value after leaving WAIT_PAY but is qualified only by fee_valid.

## Structure
- Shared package parking_pkg holds:
  - constants CAR_SLOTS=3, ID_W=2, TIME_W=8, FEE_W=12;
  - the enum type for the FSM state.
- Sub-module parking_fee_calc is combinational. It takes entry_r, now_r and RATE and produces fee (wrap subtraction, minimum unit, multiply). The FSM registers its output in CALC.

## Test plan
- Normal exit:
  - Setup: slot 1 occupied, entry_time=10, current_time=25, RATE=2.
  - Expect: fee=30, fee_valid in cycle 3.
  - Then pay_done gives slot_release/release_id=1 for one cycle and gate_open for exactly 4 cycles.
- Wrap-around: entry_time=250, current_time=5 → fee=22 (dur 11).
- Zero duration: entry_time=40, current_time=40 → fee=2 (minimum one unit).
- Rejects:
  - exit_car_id=3 → error pulse, buf_read_enable never asserted, back to IDLE.
  - Slot 0 unoccupied with id 0 → same response.
- Cancel and priority:
  - exit_cancel in WAIT_PAY → IDLE, no slot_release, no gate_open.
  - pay_done and exit_cancel in the same cycle → OPEN path taken.
- Reset and ignored requests:
  - Reset asserted during OPEN cycle 2 → gate_open, busy and slot_release drop at once.
  - Next exit_req is processed normally.
  - exit_req held high during WAIT_PAY has no effect.
